// File: rtl/regfile_pkg.sv
// Shared constants and types for the debug-capable register file.
package regfile_pkg;

    localparam int PC_IDX = 15;
    localparam int LR_IDX = 14;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Register-dump streamer: walks indices 0..NREGS-1 under a valid/ready handshake.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dump_start,
    input  logic                     dump_ready,
    output logic                     dump_busy,
    output logic                     dump_valid,
    output logic [$clog2(NREGS)-1:0] dump_idx,
    output logic                     dump_last
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] PRE_LAST_IDX = AW'(NREGS - 2);

    dump_state_t   state_r;
    logic [AW-1:0] idx_r;
    logic          valid_r;
    logic          busy_r;
    logic          last_r;

    // Dump state, index counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= {AW{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (dump_start) begin
                        state_r <= STREAM;
                        idx_r   <= {AW{1'b0}};
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                        last_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STREAM: begin
                    // dump_start is deliberately ignored while streaming
                    if (dump_ready && last_r) begin
                        state_r <= IDLE;
                        idx_r   <= {AW{1'b0}};
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        last_r  <= 1'b0;
                    end else if (dump_ready) begin
                        idx_r  <= idx_r + {{(AW-1){1'b0}}, 1'b1};
                        last_r <= (idx_r == PRE_LAST_IDX);
                    end else begin
                        state_r <= STREAM;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= {AW{1'b0}};
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_busy  = busy_r;
    assign dump_valid = valid_r;
    assign dump_idx   = idx_r;
    assign dump_last  = last_r;

endmodule

// File: rtl/regfile_dbg.sv
// ARM-style register file with link write, optional bypass, debug export and dump port.
module regfile_dbg
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter int NDBG   = 4,
    parameter int BYPASS = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] a1,
    input  logic [$clog2(NREGS)-1:0] a2,
    output logic [WIDTH-1:0]         rd1,
    output logic [WIDTH-1:0]         rd2,
    input  logic [WIDTH-1:0]         r15,
    input  logic                     we3,
    input  logic [$clog2(NREGS)-1:0] a3,
    input  logic [WIDTH-1:0]         wd3,
    input  logic                     bl_we,
    input  logic [WIDTH-1:0]         lr_data,
    output logic [NDBG*WIDTH-1:0]    dbg_regs,
    input  logic                     dump_start,
    output logic                     dump_busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [$clog2(NREGS)-1:0] dump_idx,
    output logic [WIDTH-1:0]         dump_data,
    output logic                     dump_last
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] PC_A = AW'(PC_IDX);
    localparam logic [AW-1:0] LR_A = AW'(LR_IDX);

    logic [WIDTH-1:0] regs_r [NREGS];
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;
    logic [WIDTH-1:0] dump_data_s;

    // PC is never stored; the link write takes priority over a port write to LR.
    function automatic logic [WIDTH-1:0] read_mux(
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] stored,
        input logic [WIDTH-1:0] pc_val,
        input logic             we,
        input logic [AW-1:0]    wa,
        input logic [WIDTH-1:0] wd,
        input logic             lr_we,
        input logic [WIDTH-1:0] lr_val
    );
        if (addr == PC_A) begin
            return pc_val;
        end else if ((BYPASS != 0) && lr_we && (addr == LR_A)) begin
            return lr_val;
        end else if ((BYPASS != 0) && we && (addr == wa)) begin
            return wd;
        end else begin
            return stored;
        end
    endfunction

    // Register storage update.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end else if (i == PC_IDX) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end else if (bl_we && (i == LR_IDX)) begin
                regs_r[i] <= lr_data;
            end else if (we3 && (a3 == AW'(i))) begin
                regs_r[i] <= wd3;
            end else begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

    // Combinational read ports.
    always_comb begin
        rd1_s = read_mux(a1, regs_r[a1], r15, we3, a3, wd3, bl_we, lr_data);
        rd2_s = read_mux(a2, regs_r[a2], r15, we3, a3, wd3, bl_we, lr_data);
    end

    assign rd1 = rd1_s;
    assign rd2 = rd2_s;

    // Dump data tracks live register content, not a snapshot.
    always_comb begin
        dump_data_s = regs_r[dump_idx];
        if (dump_idx == PC_A) begin
            dump_data_s = r15;
        end else begin
            dump_data_s = regs_r[dump_idx];
        end
    end

    assign dump_data = dump_data_s;

    for (genvar g = 0; g < NDBG; g++) begin : g_dbg
        assign dbg_regs[g*WIDTH +: WIDTH] = regs_r[g];
    end

    regfile_dump_fsm #(
        .NREGS(NREGS)
    ) u_dump_fsm (
        .clk        (clk),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_last  (dump_last)
    );

endmodule

// File: tb/tb_regfile_dbg.sv
// Self-checking bench: register file writes, link/bypass rules and scoreboarded dumps.
module tb_regfile_dbg;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   a1, a2, a3;
    logic [31:0]  r15, wd3, lr_data;
    logic         we3, bl_we, dump_start, dump_ready;

    logic [31:0]  rd1, rd2, dump_data;
    logic [127:0] dbg_regs;
    logic         dump_busy, dump_valid, dump_last;
    logic [3:0]   dump_idx;

    logic [31:0]  rd1_b, rd2_b, dump_data_b;
    logic [127:0] dbg_regs_b;
    logic         dump_busy_b, dump_valid_b, dump_last_b;
    logic [3:0]   dump_idx_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       sb_q [$];
    logic [31:0] model_r [16];

    always #5 clk = ~clk;

    regfile_dbg #(.WIDTH(32), .NREGS(16), .NDBG(4), .BYPASS(0)) u_dut (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .r15(r15),
        .we3(we3), .a3(a3), .wd3(wd3), .bl_we(bl_we), .lr_data(lr_data),
        .dbg_regs(dbg_regs), .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .dump_last(dump_last)
    );

    regfile_dbg #(.WIDTH(32), .NREGS(16), .NDBG(4), .BYPASS(1)) u_dut_byp (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1_b), .rd2(rd2_b), .r15(r15),
        .we3(we3), .a3(a3), .wd3(wd3), .bl_we(bl_we), .lr_data(lr_data),
        .dbg_regs(dbg_regs_b), .dump_start(dump_start), .dump_busy(dump_busy_b),
        .dump_valid(dump_valid_b), .dump_ready(dump_ready), .dump_idx(dump_idx_b),
        .dump_data(dump_data_b), .dump_last(dump_last_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        return (a == 4'd15) ? r15 : model_r[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model_r[i] = 32'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we3 = 1'b1; a3 = a; wd3 = d;
        cyc();
        we3 = 1'b0;
        if (a != 4'd15) model_r[a] = d;
    endtask

    task automatic run_dump(input bit toggle, input int abort_beat);
        int    beats = 0;
        int    cycles = 0;
        beat_t b;
        for (int i = 0; i < 16; i++) begin
            b.idx  = 4'(i);
            b.data = exp_rd(4'(i));
            b.last = (i == 15);
            sb_q.push_back(b);
        end
        dump_start = 1'b1;
        dump_ready = 1'b0;
        @(negedge clk);
        check_eq("dump_start_latency", 64'(dump_valid), 64'h0);
        while (sb_q.size() != 0 && cycles < 100) begin
            cyc();
            cycles++;
            if (abort_beat >= 0 && beats == abort_beat) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0; dump_start = 1'b0; dump_ready = 1'b0; a1 = 4'd14;
                @(negedge clk);
                check_eq("abort_valid", 64'(dump_valid), 64'h0);
                check_eq("abort_busy", 64'(dump_busy), 64'h0);
                check_eq("abort_idx", 64'(dump_idx), 64'h0);
                check_eq("abort_dbg_lo", dbg_regs[63:0], 64'h0);
                check_eq("abort_dbg_hi", dbg_regs[127:64], 64'h0);
                check_eq("abort_r14", 64'(rd1), 64'h0);
                sb_q.delete();
                clear_model();
                return;
            end
            dump_ready = toggle ? (cycles % 2 == 1) : 1'b1;
            @(negedge clk);
            b = sb_q[0];
            check_eq("dump_valid", 64'(dump_valid), 64'h1);
            check_eq("dump_busy", 64'(dump_busy), 64'h1);
            check_eq("dump_idx", 64'(dump_idx), 64'(b.idx));
            check_eq("dump_data", 64'(dump_data), 64'(b.data));
            check_eq("dump_last", 64'(dump_last), 64'(b.last));
            check_eq("dump_data_byp", 64'(dump_data_b), 64'(b.data));
            if (dump_ready) begin
                void'(sb_q.pop_front());
                beats++;
            end
        end
        if (sb_q.size() != 0) begin
            check_eq("dump_timeout", 64'(sb_q.size()), 64'h0);
            sb_q.delete();
        end
        // dump_start stays high across the final transfer edge and must be ignored
        cyc();
        dump_start = 1'b0;
        dump_ready = 1'b0;
        @(negedge clk);
        check_eq("dump_end_valid", 64'(dump_valid), 64'h0);
        check_eq("dump_end_busy", 64'(dump_busy), 64'h0);
        check_eq("dump_end_idx", 64'(dump_idx), 64'h0);
        check_eq("dump_end_busy_byp", 64'(dump_busy_b), 64'h0);
    endtask

    initial begin
        reset = 1'b1; a1 = 4'd0; a2 = 4'd15; a3 = 4'd0;
        r15 = 32'h0000_0108; wd3 = 32'h0; lr_data = 32'h0;
        we3 = 1'b0; bl_we = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        clear_model();
        repeat (2) cyc();
        @(negedge clk);
        check_eq("rst_valid", 64'(dump_valid), 64'h0);
        check_eq("rst_busy", 64'(dump_busy), 64'h0);
        check_eq("rst_idx", 64'(dump_idx), 64'h0);
        check_eq("rst_last", 64'(dump_last), 64'h0);
        check_eq("rst_data", 64'(dump_data), 64'h0);
        check_eq("rst_dbg_lo", dbg_regs[63:0], 64'h0);
        check_eq("rst_dbg_hi", dbg_regs[127:64], 64'h0);
        check_eq("rst_rd1", 64'(rd1), 64'h0);
        check_eq("rst_rd2_pc", 64'(rd2), 64'h108);

        cyc();
        reset = 1'b0; we3 = 1'b1; a3 = 4'd1; wd3 = 32'h0000_000F; a1 = 4'd1;
        @(negedge clk);
        check_eq("wr_old_rd1", 64'(rd1), 64'h0);
        check_eq("wr_byp_rd1", 64'(rd1_b), 64'h0000_000F);
        cyc();
        we3 = 1'b0; model_r[1] = 32'h0000_000F;
        @(negedge clk);
        check_eq("wr_rd1", 64'(rd1), 64'h0000_000F);
        check_eq("wr_dbg_r1", 64'(dbg_regs[63:32]), 64'h0000_000F);
        cyc();
        a1 = 4'd15;
        @(negedge clk);
        check_eq("rd_pc", 64'(rd1), 64'h108);

        wr(4'd15, 32'hDEAD_BEEF);
        a1 = 4'd15;
        @(negedge clk);
        check_eq("pc_write_dropped", 64'(rd1), 64'h108);

        cyc();
        we3 = 1'b1; a3 = 4'd14; wd3 = 32'h1111_1111; bl_we = 1'b1; lr_data = 32'h0000_0024;
        cyc();
        we3 = 1'b1; a3 = 4'd2; wd3 = 32'h0000_A5A5; bl_we = 1'b1; lr_data = 32'h0000_0030;
        a1 = 4'd14;
        @(negedge clk);
        check_eq("bl_wins", 64'(rd1), 64'h0000_0024);
        cyc();
        we3 = 1'b0; bl_we = 1'b0; a1 = 4'd2; a2 = 4'd14;
        model_r[2] = 32'h0000_A5A5; model_r[14] = 32'h0000_0030;
        @(negedge clk);
        check_eq("both_r2", 64'(rd1), 64'h0000_A5A5);
        check_eq("both_r14", 64'(rd2), 64'h0000_0030);

        cyc();
        we3 = 1'b1; a3 = 4'd3; wd3 = 32'h1234_5678; a2 = 4'd3;
        @(negedge clk);
        check_eq("nobyp_rd2", 64'(rd2), 64'h0);
        check_eq("byp_rd2", 64'(rd2_b), 64'h1234_5678);
        cyc();
        model_r[3] = 32'h1234_5678;
        we3 = 1'b1; a3 = 4'd14; wd3 = 32'h9999_9999; bl_we = 1'b1; lr_data = 32'h0000_0077; a1 = 4'd14;
        @(negedge clk);
        check_eq("nobyp_lr", 64'(rd1), 64'h0000_0030);
        check_eq("byp_lr", 64'(rd1_b), 64'h0000_0077);
        cyc();
        we3 = 1'b0; bl_we = 1'b0; model_r[14] = 32'h0000_0077;
        @(negedge clk);
        check_eq("dbg_r3", 64'(dbg_regs[127:96]), 64'h1234_5678);
        check_eq("dbg_r2_byp", 64'(dbg_regs_b[95:64]), 64'h0000_A5A5);

        cyc();
        for (int i = 0; i < 4; i++) wr(4'(i), 32'(i + 1));
        run_dump(1'b1, -1);
        cyc();
        run_dump(1'b0, 5);
        cyc();
        run_dump(1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
